calc2_core: RTL and testbench

- Parametrised multi-port integer calculator; next generation of the calc1 engine.
- NUM_PORTS request ports use the calc1 two-cycle command protocol: command plus operand 1, then operand 2.
- Each port has its own request FIFO. A round-robin arbiter feeds one shared single-cycle ALU.
- Each result returns on the originating port with a response code. out_busy provides backpressure.

---
 rtl/calc2_core_if.sv | 13 +
 rtl/calc2_core.sv | 128 ++++++++++++
 tb/tb_calc2_core.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/calc2_core_if.sv
// calc2_core_if: per-port request/response bundle for calc2_core.
interface calc2_core_if #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 32
);
  logic [4*NUM_PORTS-1:0]     req_cmd_in;
  logic [WIDTH*NUM_PORTS-1:0] req_data_in;
  logic [WIDTH*NUM_PORTS-1:0] out_data;
  logic [2*NUM_PORTS-1:0]     out_resp;
  logic [NUM_PORTS-1:0]       out_busy;
  modport master (output req_cmd_in, req_data_in, input out_data, out_resp, out_busy);
  modport slave  (input req_cmd_in, req_data_in, output out_data, out_resp, out_busy);
endinterface

// File: rtl/calc2_core.sv
// calc2_core: multi-port two-cycle calculator; per-port request FIFOs feed one
// shared single-cycle ALU through a round-robin arbiter.
module calc2_core #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 2
) (
  input logic         c_clk,
  input logic         reset,
  calc2_core_if.slave io
);
  typedef enum logic {IDLE, OP2} state_t;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int EW = 4 + 2 * WIDTH;
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ALMOST = (AW+1)'(DEPTH - 1);
  state_t           state_q [NUM_PORTS];
  state_t           state_d [NUM_PORTS];
  logic [3:0]       cmd_q   [NUM_PORTS];
  logic [3:0]       cmd_d   [NUM_PORTS];
  logic [WIDTH-1:0] op1_q   [NUM_PORTS];
  logic [WIDTH-1:0] op1_d   [NUM_PORTS];
  logic [EW-1:0]    mem_q   [NUM_PORTS][DEPTH];
  logic [EW-1:0]    mem_d   [NUM_PORTS][DEPTH];
  logic [AW-1:0]    wr_q    [NUM_PORTS];
  logic [AW-1:0]    wr_d    [NUM_PORTS];
  logic [AW-1:0]    rd_q    [NUM_PORTS];
  logic [AW-1:0]    rd_d    [NUM_PORTS];
  logic [AW:0]      cnt_q   [NUM_PORTS];
  logic [AW:0]      cnt_d   [NUM_PORTS];
  logic [WIDTH-1:0] data_q  [NUM_PORTS];
  logic [WIDTH-1:0] data_d  [NUM_PORTS];
  logic [1:0]       resp_q  [NUM_PORTS];
  logic [1:0]       resp_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0] busy_q, busy_d;
  logic [PW-1:0]    ptr_q, ptr_d, gnt;
  logic             gnt_vld;
  logic [EW-1:0]    head;
  logic [3:0]       h_cmd;
  logic [WIDTH-1:0] h_op1, h_op2, res_data;
  logic [WIDTH:0]   sum;
  logic [1:0]       res_resp;
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (!gnt_vld && cnt_q[(int'(ptr_q) + i) % NUM_PORTS] != '0) begin
        gnt_vld = 1'b1;
        gnt = PW'((int'(ptr_q) + i) % NUM_PORTS);
      end
  end
  assign head  = mem_q[gnt][rd_q[gnt]];
  assign h_cmd = head[EW-1 -: 4];
  assign h_op1 = head[2*WIDTH-1 -: WIDTH];
  assign h_op2 = head[WIDTH-1:0];
  assign sum   = {1'b0, h_op1} + {1'b0, h_op2};
  // Overflow, underflow and unknown opcodes all collapse to resp 2 with zero data
  assign res_data = h_cmd == 4'd1 ? (sum[WIDTH] ? '0 : sum[WIDTH-1:0]) :
                    h_cmd == 4'd2 ? (h_op2 > h_op1 ? '0 : h_op1 - h_op2) :
                    h_cmd == 4'd5 ? h_op1 << h_op2[SW-1:0] :
                    h_cmd == 4'd6 ? h_op1 >> h_op2[SW-1:0] : '0;
  assign res_resp = ((h_cmd == 4'd1 && !sum[WIDTH]) || (h_cmd == 4'd2 && h_op2 <= h_op1) ||
                     h_cmd == 4'd5 || h_cmd == 4'd6) ? 2'd1 : 2'd2;
  always_comb begin
    logic push, pop, start;
    logic [3:0] cin;
    logic [WIDTH-1:0] din;
    push = 1'b0;
    pop = 1'b0;
    start = 1'b0;
    cin = '0;
    din = '0;
    ptr_d = gnt_vld ? PW'((int'(gnt) + 1) % NUM_PORTS) : ptr_q;
    mem_d = mem_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cin = io.req_cmd_in[4*p +: 4];
      din = io.req_data_in[WIDTH*p +: WIDTH];
      push = state_q[p] == OP2;
      pop = gnt_vld && int'(gnt) == p;
      start = !push && cin != 4'd0 && !busy_q[p];
      state_d[p] = start ? OP2 : IDLE;
      cmd_d[p] = start ? cin : cmd_q[p];
      op1_d[p] = start ? din : op1_q[p];
      if (push) mem_d[p][wr_q[p]] = {cmd_q[p], op1_q[p], din};
      wr_d[p] = wr_q[p] + AW'(push);
      rd_d[p] = rd_q[p] + AW'(pop);
      cnt_d[p] = cnt_q[p] + (AW+1)'(push) - (AW+1)'(pop);
      // Busy one cycle early while OP2 will consume the last free slot
      busy_d[p] = cnt_d[p] == FULL || (cnt_d[p] == ALMOST && state_d[p] == OP2);
      data_d[p] = pop ? res_data : '0;
      resp_d[p] = pop ? res_resp : 2'd0;
    end
  end
  always_ff @(posedge c_clk or negedge reset)
    if (!reset) begin
      ptr_q <= '0;
      busy_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= IDLE;
        cmd_q[p] <= '0;
        op1_q[p] <= '0;
        wr_q[p] <= '0;
        rd_q[p] <= '0;
        cnt_q[p] <= '0;
        data_q[p] <= '0;
        resp_q[p] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      busy_q <= busy_d;
      state_q <= state_d;
      cmd_q <= cmd_d;
      op1_q <= op1_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      resp_q <= resp_d;
    end
  always_ff @(posedge c_clk) mem_q <= mem_d;
  assign io.out_busy = busy_q;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    assign io.out_data[WIDTH*g +: WIDTH] = data_q[g];
    assign io.out_resp[2*g +: 2] = resp_q[g];
  end
endmodule

// File: tb/tb_calc2_core.sv
// tb_calc2_core: scoreboard bench for calc2_core with 4 ports, 32-bit data, depth 2.
module tb_calc2_core;
  localparam int NP = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [33:0] exp_q [NP][$];
  int seen[$];
  int seen_cyc[$];
  calc2_core_if #(.NUM_PORTS(NP), .WIDTH(32)) bus ();
  calc2_core #(.NUM_PORTS(NP), .WIDTH(32), .DEPTH(2)) dut (.c_clk(clk), .reset(rst_n), .io(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [33:0] model(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (c)
      4'd1: return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
      4'd2: return b > a ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5: return {2'd1, a << b[4:0]};
      4'd6: return {2'd1, a >> b[4:0]};
      default: return {2'd2, 32'd0};
    endcase
  endfunction
  function automatic int pending();
    int n = 0;
    for (int p = 0; p < NP; p++) n += exp_q[p].size();
    return n;
  endfunction
  always @(negedge clk) begin
    int n;
    logic [33:0] got;
    n = 0;
    for (int p = 0; p < NP; p++)
      if (bus.out_resp[2*p +: 2] != 2'd0) begin
        n++;
        seen.push_back(p);
        seen_cyc.push_back(cyc);
        got = {bus.out_resp[2*p +: 2], bus.out_data[32*p +: 32]};
        if (exp_q[p].size() == 0) check($sformatf("unexpected_p%0d", p), got, 0);
        else check($sformatf("result_p%0d", p), got, exp_q[p].pop_front());
      end
    if (n > 1) check("one_result_per_cycle", n, 1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(int p, logic [3:0] c, logic [31:0] d);
    bus.req_cmd_in[4*p +: 4] = c;
    bus.req_data_in[32*p +: 32] = d;
  endtask
  task automatic send(int p, logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [33:0] e);
    drv(p, c, a);
    step();
    drv(p, 4'hA, b);
    exp_q[p].push_back(e);
    step();
    drv(p, 4'd0, 32'd0);
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && pending() > 0; i++) step();
    check("drain", pending(), 0);
  endtask
  task automatic burst(int first);
    seen.delete();
    seen_cyc.delete();
    for (int p = 0; p < NP; p++) drv(p, 4'd1, 32'(p));
    step();
    for (int p = 0; p < NP; p++) begin
      drv(p, 4'hA, 32'd1);
      exp_q[p].push_back({2'd1, 32'(p + 1)});
    end
    step();
    for (int p = 0; p < NP; p++) drv(p, 4'd0, 32'd0);
    drain();
    check("burst_count", seen.size(), NP);
    for (int i = 0; i < NP; i++)
      if (i < seen.size()) begin
        check($sformatf("burst_order%0d", i), seen[i], (first + i) % NP);
        if (i > 0) check($sformatf("burst_gap%0d", i), seen_cyc[i] - seen_cyc[i-1], 1);
      end
  endtask
  // All ports issue back-to-back while a bench-side occupancy model predicts out_busy
  task automatic run(int n);
    int q [NP];
    bit ph [NP];
    bit d1 [NP];
    bit d2 [NP];
    bit eb, busy_seen;
    logic [3:0] pc [NP];
    logic [31:0] pa [NP];
    logic [31:0] b;
    logic [3:0] ops [6];
    ops = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd7};
    busy_seen = 1'b0;
    for (int p = 0; p < NP; p++) begin
      q[p] = 0;
      ph[p] = 1'b0;
      d1[p] = 1'b0;
      d2[p] = 1'b0;
    end
    for (int i = 0; i < n + 2; i++) begin
      step();
      for (int p = 0; p < NP; p++) begin
        if (d1[p]) ph[p] = 1'b1;
        if (d2[p]) begin
          ph[p] = 1'b0;
          q[p]++;
        end
        if (bus.out_resp[2*p +: 2] != 2'd0) q[p]--;
        eb = (q[p] == 2) || (q[p] == 1 && ph[p]);
        check($sformatf("busy_p%0d", p), bus.out_busy[p], eb);
        if (p == 1 && eb) busy_seen = 1'b1;
        d1[p] = 1'b0;
        d2[p] = 1'b0;
        if (ph[p]) begin
          b = $urandom;
          drv(p, 4'($urandom_range(1, 15)), b);
          exp_q[p].push_back(model(pc[p], pa[p], b));
          d2[p] = 1'b1;
        end else if (i < n && !eb) begin
          pc[p] = ops[$urandom_range(0, 5)];
          pa[p] = $urandom;
          drv(p, pc[p], pa[p]);
          d1[p] = 1'b1;
        end else if (p == 1 && i < n) drv(p, 4'd1, 32'hDEAD_BEEF);
        else drv(p, 4'd0, 32'd0);
      end
    end
    check("p1_busy_seen", busy_seen, 1);
  endtask
  initial begin
    bus.req_cmd_in = '0;
    bus.req_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", bus.out_data, 0);
    check("reset_resp", bus.out_resp, 0);
    check("reset_busy", bus.out_busy, 0);
    rst_n = 1'b1;
    step();
    send(0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, {2'd1, 32'h0200_0000});
    step();
    check("latency_resp", bus.out_resp, 8'h01);
    check("latency_data", bus.out_data, {96'd0, 32'h0200_0000});
    step();
    check("single_cycle_resp", bus.out_resp, 0);
    send(0, 4'd1, 32'hFFFF_FFFF, 32'h1, {2'd2, 32'd0});
    send(0, 4'd2, 32'h1, 32'hF, {2'd2, 32'd0});
    send(0, 4'd2, 32'd10, 32'd3, {2'd1, 32'd7});
    send(0, 4'd3, 32'd5, 32'd6, {2'd2, 32'd0});
    send(0, 4'd4, 32'd5, 32'd6, {2'd2, 32'd0});
    for (int k = 0; k < 32; k++) send(0, 4'd5, 32'd1, 32'(k), {2'd1, 32'd1 << k});
    send(0, 4'd6, 32'h8000_0000, 32'd35, {2'd1, 32'h1000_0000});
    drain();
    send(3, 4'd1, 32'd0, 32'd0, {2'd1, 32'd0});
    drain();
    burst(0);
    send(1, 4'd1, 32'd4, 32'd4, {2'd1, 32'd8});
    drain();
    burst(2);
    run(40);
    drain();
    check("idle_busy", bus.out_busy, 0);
    for (int p = 0; p < NP; p++) drv(p, 4'd1, 32'(p + 10));
    step();
    for (int p = 0; p < NP; p++) begin
      drv(p, 4'd0, 32'(p));
      exp_q[p].push_back({2'd1, 32'(2 * p + 10)});
    end
    step();
    drv(0, 4'd1, 32'd7);
    for (int p = 1; p < NP; p++) drv(p, 4'd0, 32'd0);
    step();
    rst_n = 1'b0;
    #1;
    check("async_reset_data", bus.out_data, 0);
    check("async_reset_resp", bus.out_resp, 0);
    check("async_reset_busy", bus.out_busy, 0);
    for (int p = 0; p < NP; p++) begin
      exp_q[p].delete();
      drv(p, 4'd0, 32'd0);
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (8) step();
    check("post_reset_busy", bus.out_busy, 0);
    send(0, 4'd1, 32'd2, 32'd3, {2'd1, 32'd5});
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
